// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg -- shared definitions for the serial sequence scan controller.
//   state_e     : one-hot controller state encoding (IDLE, ARM, SCAN, DONE)
//   DEF_PAT_W   : default pattern length in bits
//   DEF_CNT_W   : default match-counter width
package seq_scan_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ARM  = 4'b0010,
        S_SCAN = 4'b0100,
        S_DONE = 4'b1000
    } state_e;

    localparam int DEF_PAT_W = 5;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_scan_engine.sv
// seq_scan_engine -- serial pattern detector datapath.
// Holds the bit history, the saturating fill counter and the comparator.
// match_o is combinational: it reports that the bit being shifted in on this
// cycle completes the pattern, so the controller can register the pulse.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear_i     : clear history and fill count (session start)
//   shift_i     : accept din_i this cycle
//   din_i       : serial data bit
//   overlap_i   : 1 = keep fill count after a match
//   pattern_i   : target pattern, MSB is the first bit expected
//   match_o     : current bit completes a match
module seq_scan_engine
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             din_i,
    input  logic             overlap_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             match_o
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

    always_comb begin
        hist_d   = {hist_q[PAT_W-2:0], din_i};
        fill_inc = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
        // Compare against the history including the incoming bit.
        match_o  = shift_i && (fill_inc == FILL_W'(PAT_W)) && (hist_d == pattern_i);
        // Non-overlapping detection restarts the fill so PAT_W fresh bits are needed.
        fill_d   = (match_o && !overlap_i) ? '0 : fill_inc;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_i) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl -- session controller for a serial sequence detector.
// A session starts with start in IDLE (configuration latched), spends one
// cycle in ARM, then scans valid input bits. Each match gives a one-cycle pd
// pulse and increments match_cnt; reaching a non-zero target ends the session
// through DONE. abort returns to IDLE from ARM/SCAN without pd or done.
// Optional feature: define SEQ_SCAN_OVERLAP_EN to add the cfg_overlap port
// (overlapping detection); without it detection is always non-overlapping.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start, abort   : session control
//   cfg_pattern    : PAT_W-bit target pattern (MSB first)
//   cfg_target     : matches that end the session, 0 = free-run
//   cfg_overlap    : overlapping detection (SEQ_SCAN_OVERLAP_EN only)
//   din_valid, din : serial input bit and qualifier
//   busy           : high in ARM and SCAN
//   pd             : registered match pulse
//   match_cnt      : matches in the current session
//   done           : one-cycle pulse while in DONE
//   dbg_state      : current one-hot controller state
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
`ifdef SEQ_SCAN_OVERLAP_EN
    input  logic             cfg_overlap,
`endif
    input  logic             din_valid,
    input  logic             din,
    output logic             busy,
    output logic             pd,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic [3:0]       dbg_state
);

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] tgt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovl_q;
    logic             busy_q, pd_q, done_q;
    logic             eng_clear, eng_shift, eng_match;

    assign cnt_inc = cnt_q + 1'b1;

    // abort gates the shift so a simultaneous match is never counted.
    assign eng_clear = (state_q == S_IDLE) && start;
    assign eng_shift = (state_q == S_SCAN) && din_valid && !abort;

`ifdef SEQ_SCAN_OVERLAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_q <= 1'b0;
        end else if (eng_clear) begin
            ovl_q <= cfg_overlap;
        end
    end
`else
    assign ovl_q = 1'b0;
`endif

    seq_scan_engine #(
        .PAT_W(PAT_W)
    ) u_engine (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (eng_clear),
        .shift_i  (eng_shift),
        .din_i    (din),
        .overlap_i(ovl_q),
        .pattern_i(pat_q),
        .match_o  (eng_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pd_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pat_q   <= cfg_pattern;
                        tgt_q   <= cfg_target;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (eng_match) begin
                        pd_q  <= 1'b1;
                        cnt_q <= cnt_inc;
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign pd        = pd_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a PAT_W=5/CNT_W=8 instance and a
// PAT_W=2/CNT_W=2 instance sharing clock, reset and the serial input.
module tb_seq_scan_ctrl;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_ARM  = 4'b0010;
    localparam logic [3:0] ST_SCAN = 4'b0100;
    localparam logic [3:0] ST_DONE = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;

    logic       start = 1'b0, abort = 1'b0;
    logic [4:0] cfg_pattern = '0;
    logic [7:0] cfg_target = '0;
    logic       busy, pd, done;
    logic [7:0] match_cnt;
    logic [3:0] dbg_state;

    logic       start2 = 1'b0, abort2 = 1'b0;
    logic [1:0] cfg_pattern2 = '0;
    logic [1:0] cfg_target2 = '0;
    logic       busy2, pd2, done2;
    logic [1:0] match_cnt2;
    logic [3:0] dbg_state2;

`ifdef SEQ_SCAN_OVERLAP_EN
    logic       cfg_overlap = 1'b0;
    logic       cfg_overlap2 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    seq_scan_ctrl #(.PAT_W(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_target(cfg_target),
`ifdef SEQ_SCAN_OVERLAP_EN
        .cfg_overlap(cfg_overlap),
`endif
        .din_valid(din_valid), .din(din),
        .busy(busy), .pd(pd), .match_cnt(match_cnt), .done(done),
        .dbg_state(dbg_state)
    );

    seq_scan_ctrl #(.PAT_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .cfg_pattern(cfg_pattern2), .cfg_target(cfg_target2),
`ifdef SEQ_SCAN_OVERLAP_EN
        .cfg_overlap(cfg_overlap2),
`endif
        .din_valid(din_valid), .din(din),
        .busy(busy2), .pd(pd2), .match_cnt(match_cnt2), .done(done2),
        .dbg_state(dbg_state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sess1(input logic [4:0] pat, input logic [7:0] tgt, input logic ov);
        cfg_pattern = pat;
        cfg_target  = tgt;
`ifdef SEQ_SCAN_OVERLAP_EN
        cfg_overlap = ov;
`else
        if (ov) $display("note: overlap requested without overlap build");
`endif
        start = 1'b1;
        cyc();
        chk("arm_state", dbg_state, ST_ARM);
        chk("arm_busy", busy, 1'b1);
        chk("arm_cnt", match_cnt, 8'd0);
        start = 1'b0;
        cyc();
        chk("scan_state", dbg_state, ST_SCAN);
    endtask

    task automatic bit1(input string tag, input logic b, input logic pd_exp);
        din = b;
        din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        chk(tag, pd, pd_exp);
    endtask

    task automatic stream1(input string tag, input logic [15:0] bits, input int n,
                           input logic [15:0] mask);
        for (int i = n - 1; i >= 0; i--) bit1(tag, bits[i], mask[i]);
    endtask

    task automatic end1();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_idle", dbg_state, ST_IDLE);
    endtask

    task automatic sess2(input logic [1:0] pat, input logic ov, input logic arm_valid);
        cfg_pattern2 = pat;
        cfg_target2  = 2'd0;
`ifdef SEQ_SCAN_OVERLAP_EN
        cfg_overlap2 = ov;
`else
        if (ov) $display("note: overlap requested without overlap build");
`endif
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        // A bit presented during ARM must not enter the detector.
        din = 1'b1;
        din_valid = arm_valid;
        cyc();
        din_valid = 1'b0;
        chk("scan2_state", dbg_state2, ST_SCAN);
    endtask

    task automatic bit2(input string tag, input logic b, input logic pd_exp,
                        input logic [1:0] cnt_exp);
        din = b;
        din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        chk({tag, "_pd"}, pd2, pd_exp);
        chk({tag, "_cnt"}, match_cnt2, cnt_exp);
        chk({tag, "_done"}, done2, 1'b0);
    endtask

    task automatic end2();
        abort2 = 1'b1;
        cyc();
        abort2 = 1'b0;
        chk("abort2_idle", dbg_state2, ST_IDLE);
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_pd", pd, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", match_cnt, 8'd0);
        chk("rst_state2", dbg_state2, ST_IDLE);
        rst = 1'b0;
        cyc();

        // Target 2, non-overlap; cfg changes and start pulses mid-session are ignored
        sess1(5'b00101, 8'd2, 1'b0);
        cfg_pattern = 5'b11111;
        cfg_target  = 8'd1;
        stream1("t2_first", 16'b00101, 5, 16'b00001);
        chk("t2_cnt1", match_cnt, 8'd1);
        chk("t2_nodone", done, 1'b0);
        chk("t2_busy", busy, 1'b1);
        start = 1'b1;
        stream1("t2_mid", 16'b001, 3, 16'b000);
        start = 1'b0;
        chk("t2_still_scan", dbg_state, ST_SCAN);
        chk("t2_cnt_kept", match_cnt, 8'd1);
        stream1("t2_last", 16'b01, 2, 16'b01);
        chk("t2_done", done, 1'b1);
        chk("t2_cnt2", match_cnt, 8'd2);
        chk("t2_state_done", dbg_state, ST_DONE);
        chk("t2_busy_off", busy, 1'b0);
        cyc();
        chk("t2_idle", dbg_state, ST_IDLE);
        chk("t2_done_off", done, 1'b0);
        chk("t2_pd_off", pd, 1'b0);
        chk("t2_cnt_hold", match_cnt, 8'd2);

        // din_valid low on alternate cycles
        sess1(5'b00101, 8'd0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            bit1("gap_valid", i[0] ? 1'b0 : (i == 0 || i == 2), (i == 0));
            din = 1'($urandom_range(0, 1));
            cyc();
            chk("gap_idle", pd, 1'b0);
        end
        chk("gap_cnt", match_cnt, 8'd1);
        end1();
        chk("gap_cnt_hold", match_cnt, 8'd1);

        // Abort on the completing bit of the second match (would also reach target)
        sess1(5'b00101, 8'd2, 1'b0);
        stream1("ab_first", 16'b00101, 5, 16'b00001);
        stream1("ab_pre", 16'b0010, 4, 16'b0000);
        din = 1'b1;
        din_valid = 1'b1;
        abort = 1'b1;
        cyc();
        din_valid = 1'b0;
        abort = 1'b0;
        chk("ab_pd", pd, 1'b0);
        chk("ab_done", done, 1'b0);
        chk("ab_state", dbg_state, ST_IDLE);
        chk("ab_busy", busy, 1'b0);
        chk("ab_cnt", match_cnt, 8'd1);
        cyc();
        chk("ab_late_pd", pd, 1'b0);
        chk("ab_late_done", done, 1'b0);

        // Abort during ARM
        start = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abarm_state", dbg_state, ST_IDLE);
        chk("abarm_busy", busy, 1'b0);

        // Reset mid-SCAN outranks abort, start and din
        sess1(5'b00101, 8'd0, 1'b0);
        stream1("rs_match", 16'b00101, 5, 16'b00001);
        din = 1'b1;
        din_valid = 1'b1;
        abort = 1'b1;
        start = 1'b1;
        rst = 1'b1;
        cyc();
        chk("rs_state", dbg_state, ST_IDLE);
        chk("rs_pd", pd, 1'b0);
        chk("rs_done", done, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_cnt", match_cnt, 8'd0);
        rst = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        din_valid = 1'b0;
        cyc();
        chk("rs_after", dbg_state, ST_IDLE);

        // Pattern 11 non-overlap, stream 1111 (ARM bit presented and ignored)
        sess2(2'b11, 1'b0, 1'b1);
        bit2("no11_b1", 1'b1, 1'b0, 2'd0);
        bit2("no11_b2", 1'b1, 1'b1, 2'd1);
        bit2("no11_b3", 1'b1, 1'b0, 2'd1);
        bit2("no11_b4", 1'b1, 1'b1, 2'd2);
        end2();

        // CNT_W=2 free-run wrap: counts 1,2,3,0,1 at every second bit
        sess2(2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bit2("wrap", 1'b1, 1'(i % 2), 2'(((i + 1) / 2) % 4));
        end
        end2();
        chk("wrap_final", match_cnt2, 2'd1);

`ifdef SEQ_SCAN_OVERLAP_EN
        // Overlap: 0010101 matches only at bit 5
        sess1(5'b00101, 8'd0, 1'b1);
        stream1("ov_a", 16'b0010101, 7, 16'b0000100);
        chk("ov_a_cnt", match_cnt, 8'd1);
        end1();
        // Overlap: 00100101 matches at bit 8
        sess1(5'b00101, 8'd0, 1'b1);
        stream1("ov_b", 16'b00100101, 8, 16'b00000001);
        chk("ov_b_cnt", match_cnt, 8'd1);
        end1();
        // Overlap pattern 11, stream 1111 -> 3 matches
        sess2(2'b11, 1'b1, 1'b0);
        bit2("ov11_b1", 1'b1, 1'b0, 2'd0);
        bit2("ov11_b2", 1'b1, 1'b1, 2'd1);
        bit2("ov11_b3", 1'b1, 1'b1, 2'd2);
        bit2("ov11_b4", 1'b1, 1'b1, 2'd3);
        end2();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
